lcm_calc: RTL

LCM_CALC -- requirements
Module: lcm_calc

---
 rtl/lcm_calc_if.sv | 21 ++
 rtl/lcm_calc.sv | 136 +++++++++++++
 2 files changed

// File: rtl/lcm_calc_if.sv
// Handshake and result bundle for lcm_calc.
// The gcd signal exists only when LCM_CALC_GCD_PORT_EN is defined.
interface lcm_calc_if #(
  parameter int WIDTH = 7
);
  logic               start;
  logic [WIDTH-1:0]   ia;
  logic [WIDTH-1:0]   ib;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] lcm;
`ifdef LCM_CALC_GCD_PORT_EN
  logic [WIDTH-1:0]   gcd;

  modport master (output start, ia, ib, input busy, done, lcm, gcd);
  modport slave  (input start, ia, ib, output busy, done, lcm, gcd);
`else
  modport master (output start, ia, ib, input busy, done, lcm);
  modport slave  (input start, ia, ib, output busy, done, lcm);
`endif
endinterface

// File: rtl/lcm_calc.sv
// Sequential LCM: binary GCD, restoring divide oa/g, shift-add multiply by ob.
// Optional gcd output register controlled by macro LCM_CALC_GCD_PORT_EN.
module lcm_calc #(
  parameter int WIDTH = 7
) (
  input  logic        clk,
  input  logic        rst_,
  lcm_calc_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, GCD, DIV, MUL, DONE} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   a_reg, b_reg, oa_reg, ob_reg, g_reg;
  logic [WIDTH-1:0]   rem_reg, dq_reg;
  logic [CW-1:0]      k_reg, cnt_reg;
  logic [2*WIDTH-1:0] mc_reg, acc_reg;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     g_ext;

  // Restoring-division trial: shift next dividend bit into the partial remainder.
  assign trial = {rem_reg, dq_reg[WIDTH-1]};
  assign g_ext = {1'b0, g_reg};

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      oa_reg    <= '0;
      ob_reg    <= '0;
      g_reg     <= '0;
      rem_reg   <= '0;
      dq_reg    <= '0;
      k_reg     <= '0;
      cnt_reg   <= '0;
      mc_reg    <= '0;
      acc_reg   <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.lcm   <= '0;
`ifdef LCM_CALC_GCD_PORT_EN
      bus.gcd   <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg    <= bus.ia;
            b_reg    <= bus.ib;
            oa_reg   <= bus.ia;
            ob_reg   <= bus.ib;
            k_reg    <= '0;
            bus.busy <= 1'b1;
            if (bus.ia == '0 || bus.ib == '0) begin
              acc_reg   <= '0;
              g_reg     <= (bus.ia > bus.ib) ? bus.ia : bus.ib;
              state_reg <= DONE;
            end else begin
              state_reg <= GCD;
            end
          end
        end

        GCD: begin
          if (a_reg == b_reg) begin
            g_reg     <= a_reg << k_reg;
            dq_reg    <= oa_reg;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= DIV;
          end else if (!a_reg[0] && !b_reg[0]) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            k_reg <= k_reg + 1'b1;
          end else if (!a_reg[0]) begin
            a_reg <= a_reg >> 1;
          end else if (!b_reg[0]) begin
            b_reg <= b_reg >> 1;
          end else if (a_reg > b_reg) begin
            a_reg <= (a_reg - b_reg) >> 1;
          end else begin
            b_reg <= (b_reg - a_reg) >> 1;
          end
        end

        // dq_reg doubles as dividend shifter and quotient accumulator.
        DIV: begin
          if (trial >= g_ext) begin
            rem_reg <= WIDTH'(trial - g_ext);
            dq_reg  <= {dq_reg[WIDTH-2:0], 1'b1};
          end else begin
            rem_reg <= trial[WIDTH-1:0];
            dq_reg  <= {dq_reg[WIDTH-2:0], 1'b0};
          end
          if (cnt_reg == CW'(WIDTH - 1)) begin
            cnt_reg   <= '0;
            acc_reg   <= '0;
            mc_reg    <= {{WIDTH{1'b0}}, ob_reg};
            state_reg <= MUL;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        MUL: begin
          if (dq_reg[0]) begin
            acc_reg <= acc_reg + mc_reg;
          end
          mc_reg <= mc_reg << 1;
          dq_reg <= dq_reg >> 1;
          if (cnt_reg == CW'(WIDTH - 1)) begin
            cnt_reg   <= '0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DONE: begin
          bus.lcm   <= acc_reg;
`ifdef LCM_CALC_GCD_PORT_EN
          bus.gcd   <= g_reg;
`endif
          bus.done  <= 1'b1;
          bus.busy  <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
